foo_requester: RTL and testbench

- Initiator side of the foo REQ/ACK interface.
- Buffers up to FIFO_DEPTH commands from a local client and drives MY_ADDR/REQ/qualifier into a foo responder using a four-phase handshake.
- Captures the responder's two status outputs and reports per-transaction completion or timeout back to the client.
- Sits between the client logic and a foo instance in the same clock domain.

---
 rtl/foo_requester.sv | 193 +++++++++++++++++++
 tb/tb_foo_requester.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/foo_requester.sv
// rtl/foo_requester.sv - foo REQ/ACK initiator with command FIFO, four-phase handshake and timeout
// Commands queue locally; one handshake at a time drives the responder and reports done/timeout.
module foo_requester #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       CMD_VALID_IN,
    input  logic [1:0] CMD_ADDR_IN,
    input  logic       CMD_FLAG_IN,
    output logic       CMD_READY_OUT,
    output logic [1:0] MY_ADDR_OUT,
    output logic       REQ_OUT,
    output logic       THIS_NAME_LONGER_OUT,
    input  logic       ACK_IN,
    input  logic       THIS_IS_LONGER_NAME_IN,
    input  logic       THIS_IS_ANOTHER_LONG_NAME_IN,
    output logic       DONE_OUT,
    output logic [1:0] DONE_STATUS_OUT,
    output logic       TIMEOUT_OUT,
    output logic       BUSY_OUT
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [PTR_W:0] FULL_COUNT = FCNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [2:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             req_q, req_d;
    logic [1:0]       addr_q, addr_d;
    logic             flag_q, flag_d;
    logic [1:0]       cap_q, cap_d;
    logic [1:0]       status_q, status_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic             push;
    logic             pop;
    logic [2:0]       head;
    logic [CNT_W-1:0] tmo_cnt_inc;
    logic             tmo_hit;

    // Full refuses a push even when the FSM pops in the same cycle.
    assign CMD_READY_OUT = (count_q != FULL_COUNT);
    assign push          = CMD_VALID_IN && CMD_READY_OUT;
    // A responder still holding ACK (spurious or late) blocks the next request.
    assign pop           = (state_q == IDLE) && (count_q != '0) && !ACK_IN;
    assign head          = mem_q[rd_ptr_q];

    // tmo_cnt_inc is the number of cycles spent in the wait state including this one.
    assign tmo_cnt_inc   = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    assign tmo_hit       = TIMEOUT_EN && (tmo_cnt_inc == TIMEOUT_VAL);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {CMD_FLAG_IN, CMD_ADDR_IN};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        req_d     = req_q;
        addr_d    = addr_q;
        flag_d    = flag_q;
        cap_d     = cap_q;
        status_d  = status_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                if (pop) begin
                    addr_d  = head[1:0];
                    flag_d  = head[2];
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (ACK_IN) begin
                    cap_d     = {THIS_IS_ANOTHER_LONG_NAME_IN, THIS_IS_LONGER_NAME_IN};
                    req_d     = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = REQ_LO;
                end else if (tmo_hit) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = DRAIN;
                end
            end
            REQ_LO: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (!ACK_IN) begin
                    done_d    = 1'b1;
                    status_d  = cap_q;
                    tmo_cnt_d = '0;
                    state_d   = IDLE;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                tmo_cnt_d = '0;
                if (!ACK_IN) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tmo_cnt_d = '0;
                req_d     = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state_q   <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tmo_cnt_q <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            flag_q    <= 1'b0;
            cap_q     <= '0;
            status_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tmo_cnt_q <= tmo_cnt_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            flag_q    <= flag_d;
            cap_q     <= cap_d;
            status_q  <= status_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign REQ_OUT              = req_q;
    assign MY_ADDR_OUT          = addr_q;
    assign THIS_NAME_LONGER_OUT = flag_q;
    assign DONE_OUT             = done_q;
    assign DONE_STATUS_OUT      = status_q;
    assign TIMEOUT_OUT          = timeout_q;
    assign BUSY_OUT             = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_foo_requester.sv
// tb/tb_foo_requester.sv - self-checking bench for foo_requester
// Queue-based reference model compared every cycle, directed scenarios plus randomized traffic.
module tb_foo_requester;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_addr;
    logic       cmd_flag;
    logic       ack;
    logic       st0;
    logic       st1;
    logic       CMD_READY_OUT;
    logic [1:0] MY_ADDR_OUT;
    logic       REQ_OUT;
    logic       THIS_NAME_LONGER_OUT;
    logic       DONE_OUT;
    logic [1:0] DONE_STATUS_OUT;
    logic       TIMEOUT_OUT;
    logic       BUSY_OUT;

    foo_requester #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (4)
    ) dut (
        .CLK_IN                      (clk),
        .RST_IN                      (rst),
        .CMD_VALID_IN                (cmd_valid),
        .CMD_ADDR_IN                 (cmd_addr),
        .CMD_FLAG_IN                 (cmd_flag),
        .CMD_READY_OUT               (CMD_READY_OUT),
        .MY_ADDR_OUT                 (MY_ADDR_OUT),
        .REQ_OUT                     (REQ_OUT),
        .THIS_NAME_LONGER_OUT        (THIS_NAME_LONGER_OUT),
        .ACK_IN                      (ack),
        .THIS_IS_LONGER_NAME_IN      (st0),
        .THIS_IS_ANOTHER_LONG_NAME_IN(st1),
        .DONE_OUT                    (DONE_OUT),
        .DONE_STATUS_OUT             (DONE_STATUS_OUT),
        .TIMEOUT_OUT                 (TIMEOUT_OUT),
        .BUSY_OUT                    (BUSY_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting for ACK high, 2 waiting for ACK low, 3 draining.
    logic [2:0]  mq[$];
    int          ph = 0;
    int unsigned edge_n = 0;
    int unsigned ph_start = 0;
    int          spent;
    bit          acc;
    logic [2:0]  head;
    logic        m_req = 0, m_flag = 0, m_done = 0, m_tmo = 0;
    logic [1:0]  m_addr = 0, m_status = 0, m_cap = 0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            mq.delete();
            ph = 0; ph_start = edge_n;
            m_req = 0; m_flag = 0; m_done = 0; m_tmo = 0;
            m_addr = 0; m_status = 0; m_cap = 0;
        end else begin
            acc    = cmd_valid && (mq.size() != DEPTH);
            spent  = int'(edge_n - ph_start);
            m_done = 0;
            m_tmo  = 0;
            case (ph)
                0: if (mq.size() > 0 && !ack) begin
                    head   = mq.pop_front();
                    m_addr = head[1:0];
                    m_flag = head[2];
                    m_req  = 1;
                    ph = 1; ph_start = edge_n;
                end
                1: if (ack) begin
                    m_cap = {st1, st0};
                    m_req = 0;
                    ph = 2; ph_start = edge_n;
                end else if (TMO != 0 && spent == TMO) begin
                    m_req = 0; m_tmo = 1; ph = 3;
                end
                2: if (!ack) begin
                    m_done = 1; m_status = m_cap; ph = 0;
                end else if (TMO != 0 && spent == TMO) begin
                    m_tmo = 1; ph = 3;
                end
                default: if (!ack) ph = 0;
            endcase
            if (acc) mq.push_back({cmd_flag, cmd_addr});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req", REQ_OUT, m_req);
            check("my_addr", MY_ADDR_OUT, m_addr);
            check("flag", THIS_NAME_LONGER_OUT, m_flag);
            check("done", DONE_OUT, m_done);
            check("done_status", DONE_STATUS_OUT, m_status);
            check("timeout", TIMEOUT_OUT, m_tmo);
            check("ready", CMD_READY_OUT, (mq.size() != DEPTH));
            check("busy", BUSY_OUT, (ph != 0) || (mq.size() != 0));
        end
    end

    // Responder stimulus
    bit resp_auto = 0;
    bit spur_en   = 0;
    int r_max     = 3;
    int r_cnt     = 0;

    task automatic resp_step();
        if (!ack) begin
            if (REQ_OUT) begin
                if (r_cnt == 0) begin
                    ack = 1;
                    {st1, st0} = 2'($urandom_range(0, 3));
                    r_cnt = $urandom_range(0, r_max);
                end else begin
                    r_cnt--;
                end
            end else if (spur_en && $urandom_range(0, 40) == 0) begin
                ack = 1;
                r_cnt = $urandom_range(0, 3);
            end
        end else if (!REQ_OUT) begin
            if (r_cnt == 0) begin
                ack = 0;
                r_cnt = $urandom_range(0, r_max);
            end else begin
                r_cnt--;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (resp_auto) resp_step();
    endtask

    task automatic settle();
        int n = 0;
        resp_auto = 0; ack = 0; cmd_valid = 0; rst = 0;
        while (BUSY_OUT !== 1'b0 && n < 100) begin
            cycle();
            n++;
        end
        cycle();
        check("settle_idle", BUSY_OUT, 0);
    endtask

    task automatic push(input logic [1:0] a, input logic f);
        cmd_valid = 1; cmd_addr = a; cmd_flag = f;
        cycle();
        cmd_valid = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int nr;
        logic prev;
        logic [1:0] got [4];

        rst = 1; cmd_valid = 0; cmd_addr = 0; cmd_flag = 0; ack = 0; st0 = 0; st1 = 0;
        cycle();
        cycle();
        rst = 0;
        chk_en = 1;
        check("rst_ready", CMD_READY_OUT, 1);
        check("rst_req", REQ_OUT, 0);
        check("rst_busy", BUSY_OUT, 0);
        check("rst_addr", MY_ADDR_OUT, 0);
        check("rst_status", DONE_STATUS_OUT, 0);

        // Single command
        cmd_valid = 1; cmd_addr = 2'b10; cmd_flag = 1;
        cycle();
        cmd_valid = 0;
        check("single_req_n1", REQ_OUT, 0);
        cycle();
        check("single_req_n2", REQ_OUT, 1);
        check("single_addr", MY_ADDR_OUT, 2);
        check("single_flag", THIS_NAME_LONGER_OUT, 1);
        repeat (3) cycle();
        ack = 1; st0 = 1; st1 = 0;
        cycle();
        check("single_req_fall", REQ_OUT, 0);
        ack = 0;
        cycle();
        check("single_done", DONE_OUT, 1);
        check("single_status", DONE_STATUS_OUT, 2'b01);
        cycle();
        check("single_done_pulse", DONE_OUT, 0);
        check("single_busy_after", BUSY_OUT, 0);
        check("single_status_hold", DONE_STATUS_OUT, 2'b01);
        settle();

        // FIFO fill while a held ACK keeps the FSM idle
        ack = 1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            push(2'(i), 1'(i));
            if (i == 2) check("fill_ready_3", CMD_READY_OUT, 1);
            if (i == 3) check("fill_ready_4", CMD_READY_OUT, 0);
            if (i == 4) check("fill_ready_5", CMD_READY_OUT, 0);
        end
        check("fill_no_req", REQ_OUT, 0);
        ack = 0; r_cnt = 0; r_max = 3; spur_en = 0; resp_auto = 1;
        prev = REQ_OUT; nr = 0;
        for (int i = 0; i < 300 && !(nr >= 4 && BUSY_OUT === 1'b0); i++) begin
            cycle();
            if (REQ_OUT && !prev) begin
                if (nr < 4) got[nr] = MY_ADDR_OUT;
                nr++;
            end
            prev = REQ_OUT;
        end
        check("fill_count", nr, 4);
        for (int k = 0; k < 4; k++) check("fill_order", got[k], k);
        settle();

        // Timeout, next command, late ACK during drain
        ack = 1;
        cycle();
        push(2'd3, 1'b0);
        push(2'd1, 1'b1);
        push(2'd2, 1'b0);
        ack = 0;
        cycle();
        check("tmo_a_req", REQ_OUT, 1);
        check("tmo_a_addr", MY_ADDR_OUT, 3);
        n = 0;
        while (REQ_OUT === 1'b1 && n < 40) begin cycle(); n++; end
        check("tmo_a_len", n, 8);
        check("tmo_a_pulse", TIMEOUT_OUT, 1);
        check("tmo_a_nodone", DONE_OUT, 0);
        cycle();
        check("tmo_a_pulse_end", TIMEOUT_OUT, 0);
        n = 0;
        while (REQ_OUT !== 1'b1 && n < 10) begin cycle(); n++; end
        check("tmo_b_req", REQ_OUT, 1);
        check("tmo_b_addr", MY_ADDR_OUT, 1);
        check("tmo_b_flag", THIS_NAME_LONGER_OUT, 1);
        n = 0;
        while (REQ_OUT === 1'b1 && n < 40) begin cycle(); n++; end
        check("tmo_b_len", n, 8);
        check("tmo_b_pulse", TIMEOUT_OUT, 1);
        ack = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("drain_req_low", REQ_OUT, 0);
        end
        ack = 0;
        n = 0;
        while (REQ_OUT !== 1'b1 && n < 10) begin cycle(); n++; end
        check("late_c_req", REQ_OUT, 1);
        check("late_c_addr", MY_ADDR_OUT, 2);
        cycle();
        ack = 1; st0 = 1; st1 = 1;
        n = 0;
        while (REQ_OUT === 1'b1 && n < 10) begin cycle(); n++; end
        ack = 0;
        n = 0;
        while (DONE_OUT !== 1'b1 && n < 10) begin cycle(); n++; end
        check("late_c_done", DONE_OUT, 1);
        check("late_c_status", DONE_STATUS_OUT, 2'b11);
        settle();

        // ACK arriving in the very cycle the timeout would fire
        push(2'd1, 1'b0);
        n = 0;
        while (REQ_OUT !== 1'b1 && n < 10) begin cycle(); n++; end
        repeat (TMO - 1) cycle();
        check("tie_req_still_high", REQ_OUT, 1);
        ack = 1; st0 = 0; st1 = 1;
        cycle();
        check("tie_req_fall", REQ_OUT, 0);
        check("tie_no_timeout", TIMEOUT_OUT, 0);
        ack = 0;
        cycle();
        check("tie_done", DONE_OUT, 1);
        check("tie_status", DONE_STATUS_OUT, 2'b10);
        check("tie_no_timeout2", TIMEOUT_OUT, 0);
        settle();

        // Reset mid-handshake with two entries queued
        push(2'd0, 1'b1);
        push(2'd1, 1'b1);
        push(2'd2, 1'b1);
        check("rmid_req_before", REQ_OUT, 1);
        check("rmid_busy_before", BUSY_OUT, 1);
        rst = 1;
        cycle();
        rst = 0;
        check("rmid_req", REQ_OUT, 0);
        check("rmid_busy", BUSY_OUT, 0);
        check("rmid_ready", CMD_READY_OUT, 1);
        check("rmid_done", DONE_OUT, 0);
        check("rmid_timeout", TIMEOUT_OUT, 0);
        nr = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (REQ_OUT === 1'b1) nr++;
        end
        check("rmid_discarded", nr, 0);

        // Randomized traffic with random responder timing, spurious ACKs and resets
        r_cnt = 0; r_max = 11; spur_en = 1; resp_auto = 1;
        for (int i = 0; i < 4000; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_addr  = 2'($urandom_range(0, 3));
            cmd_flag  = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 0;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
